// File: rtl/led_pwm_pkg.sv
// Shared types and register map for the LED/PWM PIO peripheral.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        ModeOff   = 2'b00,
        ModeOn    = 2'b01,
        ModeBlink = 2'b10,
        ModePwm   = 2'b11
    } led_mode_t;

    localparam int unsigned RegCtrl   = 0;
    localparam int unsigned RegPresc  = 1;
    localparam int unsigned RegOut    = 2;
    localparam int unsigned RegFrame  = 3;
    localparam int unsigned RegChBase = 4;

    localparam int unsigned CtrlEnableBit = 0;
    localparam int unsigned CtrlInvertBit = 1;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: mode decode, PWM compare and blink phase tracking.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int unsigned PwmBits = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  led_mode_t          mode_i,
    input  logic [PwmBits-1:0] duty_i,
    input  logic [15:0]        period_i,
    input  logic [PwmBits-1:0] pwm_cnt_i,
    input  logic               frame_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic               enable_i,
    output logic               raw_o
);

    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d;
    logic [15:0] last_cnt;

    always_comb begin
        last_cnt    = (period_i == 16'd0) ? 16'd0 : period_i - 16'd1;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (clear_i) begin
            blink_cnt_d = 16'd0;
            phase_d     = 1'b0;
        end else if (load_i) begin
            // A fresh configuration restarts the blink in its on half.
            blink_cnt_d = 16'd0;
            phase_d     = 1'b1;
        end else if (enable_i && frame_i) begin
            if (blink_cnt_q >= last_cnt) begin
                blink_cnt_d = 16'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blink_cnt_q <= 16'd0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        raw_o = 1'b0;
        unique case (mode_i)
            ModeOff:   raw_o = 1'b0;
            ModeOn:    raw_o = 1'b1;
            ModeBlink: raw_o = phase_q;
            ModePwm:   raw_o = (pwm_cnt_i < duty_i);
            default:   raw_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pwm_pio.sv
// Avalon-MM LED peripheral: register file, prescaled timebase, N_CH channels, output flop.
module led_pwm_pio
    import led_pwm_pkg::*;
#(
    parameter  int unsigned N_CH       = 8,
    parameter  int unsigned PWM_BITS   = 8,
    parameter  int unsigned PRESC_BITS = 16,
    localparam int unsigned ADDR_W     = $clog2(4 + N_CH)
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [N_CH-1:0]   leds_export
);

    logic [1:0]            ctrl_q, ctrl_d;
    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic [PRESC_BITS-1:0] presc_cnt_q, presc_cnt_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [N_CH-1:0]       leds_q, leds_d;
    logic [31:0]           rdata_q, rdata_d, rd_mux;

    led_mode_t             mode_q   [N_CH];
    logic [PWM_BITS-1:0]   duty_q   [N_CH];
    logic [15:0]           period_q [N_CH];

    logic                  wr_ctrl, wr_presc, clear, enable, tick, frame;
    logic [N_CH-1:0]       ch_wr, raw;
    logic                  unused_wdata;

    assign unused_wdata = ^avs_writedata;

    always_comb begin
        wr_ctrl  = avs_write && (avs_address == ADDR_W'(RegCtrl));
        wr_presc = avs_write && (avs_address == ADDR_W'(RegPresc));
        for (int k = 0; k < N_CH; k++) begin
            ch_wr[k] = avs_write && (avs_address == ADDR_W'(RegChBase + k));
        end
    end

    assign enable = ctrl_q[CtrlEnableBit];
    // Disabling wipes the timebase and every channel's blink state on the write edge.
    assign clear  = wr_ctrl && !avs_writedata[CtrlEnableBit];
    assign tick   = enable && (presc_cnt_q == '0);
    assign frame  = tick && (pwm_cnt_q == '1);

    always_comb begin
        ctrl_d  = wr_ctrl ? avs_writedata[1:0] : ctrl_q;
        presc_d = wr_presc ? avs_writedata[PRESC_BITS-1:0] : presc_q;

        presc_cnt_d = presc_cnt_q - PRESC_BITS'(1);
        if (wr_presc) begin
            presc_cnt_d = avs_writedata[PRESC_BITS-1:0];
        end else if (!enable || clear || tick) begin
            presc_cnt_d = presc_q;
        end

        pwm_cnt_d   = pwm_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (clear) begin
            pwm_cnt_d   = '0;
            frame_cnt_d = 16'd0;
        end else if (tick) begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            if (frame) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ctrl_q      <= 2'b00;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            frame_cnt_q <= 16'd0;
        end else begin
            ctrl_q      <= ctrl_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int k = 0; k < N_CH; k++) begin
                mode_q[k]   <= ModeOff;
                duty_q[k]   <= '0;
                period_q[k] <= 16'd0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch_wr[k]) begin
                    mode_q[k]   <= led_mode_t'(avs_writedata[1:0]);
                    duty_q[k]   <= avs_writedata[8 +: PWM_BITS];
                    period_q[k] <= avs_writedata[31:16];
                end
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        led_pwm_channel #(
            .PwmBits (PWM_BITS)
        ) u_ch (
            .clk_i     (clk_clk),
            .rst_ni    (reset_reset_n),
            .mode_i    (mode_q[k]),
            .duty_i    (duty_q[k]),
            .period_i  (period_q[k]),
            .pwm_cnt_i (pwm_cnt_q),
            .frame_i   (frame),
            .clear_i   (clear),
            .load_i    (ch_wr[k]),
            .enable_i  (enable),
            .raw_o     (raw[k])
        );
    end

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            leds_d[k] = (enable & raw[k]) ^ ctrl_q[CtrlInvertBit];
        end
    end

    // Mux sees pre-edge register values, so a same-cycle write reads back the old value.
    always_comb begin
        rd_mux = 32'd0;
        if (avs_address == ADDR_W'(RegCtrl)) begin
            rd_mux = 32'(ctrl_q);
        end else if (avs_address == ADDR_W'(RegPresc)) begin
            rd_mux = 32'(presc_q);
        end else if (avs_address == ADDR_W'(RegOut)) begin
            rd_mux = 32'(leds_q);
        end else if (avs_address == ADDR_W'(RegFrame)) begin
            rd_mux = {frame_cnt_q, 16'(pwm_cnt_q)};
        end
        for (int k = 0; k < N_CH; k++) begin
            if (avs_address == ADDR_W'(RegChBase + k)) begin
                rd_mux = {period_q[k], 8'(duty_q[k]), 6'd0, mode_q[k]};
            end
        end
        rdata_d = avs_read ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            leds_q  <= '0;
            rdata_q <= 32'd0;
        end else begin
            leds_q  <= leds_d;
            rdata_q <= rdata_d;
        end
    end

    assign leds_export  = leds_q;
    assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_led_pwm_pio.sv
// Scoreboard bench for led_pwm_pio against a tick/frame-count reference model.
module tb_led_pwm_pio;

    localparam int N  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic          rd, wr;
    logic [31:0]   wdata, rdata;
    logic [N-1:0]  leds;

    always #5 clk = ~clk;

    led_pwm_pio #(
        .N_CH       (N),
        .PWM_BITS   (8),
        .PRESC_BITS (16)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs_address   (addr),
        .avs_read      (rd),
        .avs_write     (wr),
        .avs_writedata (wdata),
        .avs_readdata  (rdata),
        .leds_export   (leds)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic        rd_seen;

    // Reference model: timebase kept as total ticks since the last clear.
    bit          m_en, m_inv;
    int unsigned m_presc, m_age, m_ticks;
    int unsigned ch_mode[N], ch_duty[N], ch_period[N], ch_sf[N];
    bit          ch_sp[N];
    logic [N-1:0] m_leds, m_leds_nxt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_leds();
        logic [N-1:0] v;
        int unsigned frames, pwm, h;
        bit r;
        frames = m_ticks / 256;
        pwm    = m_ticks % 256;
        for (int k = 0; k < N; k++) begin
            case (ch_mode[k])
                0: r = 1'b0;
                1: r = 1'b1;
                2: begin
                    h = (ch_period[k] == 0) ? 1 : ch_period[k];
                    r = ch_sp[k] ^ ((((frames - ch_sf[k]) / h) % 2) == 1);
                end
                default: r = (pwm < ch_duty[k]);
            endcase
            v[k] = (m_en & r) ^ m_inv;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_read(input int unsigned a);
        if (a == 0) return {30'd0, m_inv, m_en};
        if (a == 1) return m_presc;
        if (a == 2) return 32'(m_leds);
        if (a == 3) return {16'(m_ticks / 256), 16'(m_ticks % 256)};
        if (a >= 4 && a < 4 + N)
            return {16'(ch_period[a-4]), 8'(ch_duty[a-4]), 6'd0, 2'(ch_mode[a-4])};
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_en = 0; m_inv = 0; m_presc = 0; m_age = 0; m_ticks = 0;
        for (int k = 0; k < N; k++) begin
            ch_mode[k] = 0; ch_duty[k] = 0; ch_period[k] = 0; ch_sf[k] = 0; ch_sp[k] = 0;
        end
        m_leds = '0;
        m_leds_nxt = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit tick, clr;
        int unsigned a;
        a = addr;
        m_leds_nxt = model_leds();
        if (rd) exp_q.push_back(model_read(a));
        tick = m_en && (m_age == m_presc);
        clr  = wr && (a == 0) && !wdata[0];
        if ((wr && a == 1) || !m_en || clr || tick) m_age = 0;
        else m_age++;
        if (clr) m_ticks = 0;
        else if (tick) m_ticks++;
        if (clr) begin
            for (int k = 0; k < N; k++) begin
                ch_sf[k] = 0;
                ch_sp[k] = 0;
            end
        end
        if (wr && a >= 4 && a < 4 + N) begin
            ch_mode[a-4]   = wdata[1:0];
            ch_duty[a-4]   = wdata[15:8];
            ch_period[a-4] = wdata[31:16];
            ch_sf[a-4]     = m_ticks / 256;
            ch_sp[a-4]     = 1;
        end
        if (wr && a == 0) begin
            m_en  = wdata[0];
            m_inv = wdata[1];
        end
        if (wr && a == 1) m_presc = wdata[15:0];
    endtask

    // Advance one clock with the currently driven bus inputs; returns at the next negedge.
    task automatic step();
        model_step();
        @(posedge clk);
        m_leds = m_leds_nxt;
        @(negedge clk);
    endtask

    task automatic bus_write(input int unsigned a, input logic [31:0] d);
        addr = AW'(a); wdata = d; wr = 1'b1;
        step();
        wr = 1'b0;
    endtask

    task automatic bus_read(input int unsigned a);
        addr = AW'(a); rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic bus_rw(input int unsigned a, input logic [31:0] d);
        addr = AW'(a); wdata = d; wr = 1'b1; rd = 1'b1;
        step();
        wr = 1'b0; rd = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_seen <= 1'b0;
        else        rd_seen <= rd;
    end

    always @(negedge clk) begin
        chk("leds", 32'(leds), 32'(m_leds));
        if (rd_seen) begin
            if (exp_q.size() == 0) chk("rdata_unexpected", rdata, 32'hDEAD_BEEF);
            else                   chk("rdata", rdata, exp_q.pop_front());
        end
    end

    initial begin
        int cnt;
        int unsigned op, k;
        logic [31:0] d;
        model_reset();
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 16; a++) bus_read(a);

        bus_write(1, 32'd0);
        bus_write(0, 32'd1);
        bus_write(5, 32'h0000_0000);
        bus_write(4, 32'h0000_0001);
        step();
        chk("ch0_on", 32'(leds), 32'h01);
        bus_write(0, 32'd3);
        step();
        chk("invert", 32'(leds), 32'hFE);
        bus_write(0, 32'd1);

        bus_write(6, 32'h0000_4003);
        repeat (3) step();
        cnt = 0;
        repeat (256) begin step(); cnt += int'(leds[2]); end
        chk("pwm_duty64", cnt, 64);
        bus_write(6, 32'h0000_0003);
        repeat (3) step();
        cnt = 0;
        repeat (256) begin step(); cnt += int'(leds[2]); end
        chk("pwm_duty0", cnt, 0);
        bus_write(6, 32'h0000_FF03);
        repeat (3) step();
        cnt = 0;
        repeat (256) begin step(); cnt += int'(leds[2]); end
        chk("pwm_duty255", cnt, 255);

        bus_write(7, 32'h0002_0002);
        step();
        chk("blink_start", 32'(leds[3]), 32'd1);
        repeat (700) step();
        bus_write(7, 32'h0002_0002);
        step();
        chk("blink_restart", 32'(leds[3]), 32'd1);
        repeat (1200) step();

        bus_write(0, 32'd0);
        bus_write(1, 32'd3);
        bus_write(0, 32'd1);
        repeat (6) begin bus_read(3); repeat (3) step(); end
        bus_write(0, 32'd0);
        bus_read(3);
        chk("frame_clr", rdata, 32'd0);
        chk("leds_off", 32'(leds), 32'd0);
        bus_rw(0, 32'd1);
        bus_read(0);

        for (int i = 0; i < 1200; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                k = $urandom_range(0, N - 1);
                d = {16'($urandom_range(0, 3)), 8'($urandom), 6'd0, 2'($urandom)};
                bus_write(4 + k, d);
            end else if (op == 4) begin
                bus_write(1, 32'($urandom_range(0, 3)));
            end else if (op == 5) begin
                d = ($urandom_range(0, 9) < 8) ? 32'd1 : 32'd0;
                d[1] = ($urandom_range(0, 4) == 0);
                bus_write(0, d);
            end else if (op <= 7) begin
                bus_read($urandom_range(0, 15));
            end else begin
                repeat ($urandom_range(0, 30)) step();
            end
        end

        bus_write(0, 32'd1);
        bus_write(1, 32'd0);
        bus_write(4, 32'h0000_0001);
        bus_write(6, 32'h0000_8003);
        repeat (40) step();
        model_step();
        @(posedge clk);
        m_leds = m_leds_nxt;
        #3 rst_n = 1'b0;
        #1 chk("async_reset_leds", 32'(leds), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) bus_read(a);
        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pwm_pio.md
# led_pwm_pio

Parametrised Avalon-MM LED/PIO peripheral that replaces the plain 8-bit `leds_export` output port of the RV system with N independently programmable channels. Each channel is off, static-on, blinking or PWM-dimmed from a shared prescaled timebase. The block sits on the processor's Avalon-MM bus as a slave, and its outputs drive the board LED pins.

## Interface
Parameters:
- `N_CH`, 8: number of output channels (1..28).
- `PWM_BITS`, 8: PWM counter and duty width (1..8).
- `PRESC_BITS`, 16: prescaler width (1..32).
- `ADDR_W`, clog2(4+N_CH): word-address width (derived, not overridden).

Ports (clock is a single domain; reset is asynchronous, active-low):
- `clk_clk`  in  1: system clock.
- `reset_reset_n`  in  1: asynchronous active-low reset.
- `avs_address`  in  ADDR_W: word address.
- `avs_read`  in  1: read strobe.
- `avs_write`  in  1: write strobe.
- `avs_writedata`  in  32: write data.
- `avs_readdata`  out  32: read data, fixed latency 1.
- `leds_export`  out  N_CH: registered channel outputs.

## Operation
- Register map, by word address:
  - 0 CTRL: [0] enable, [1] invert. R/W.
  - 1 PRESC: [PRESC_BITS-1:0] reload value. R/W.
  - 2 OUT: current `leds_export`. Read-only.
  - 3 FRAME: PWM counter in [PWM_BITS-1:0], frame count in [31:16]. Read-only.
  - 4+k CHk: [1:0] mode, [15:8] duty (low PWM_BITS bits used), [31:16] blink half-period in frames. R/W.
- Mode encoding: 00 OFF, 01 ON, 10 BLINK, 11 PWM.
- Prescaler: a down-counter reloads from PRESC and asserts a one-cycle `tick` when it reaches 0. PRESC=0 gives a tick every cycle.
- PWM counter: increments on each tick and wraps 2^PWM_BITS-1 → 0. The wrap cycle asserts `frame`. A 16-bit frame counter increments on `frame` and wraps freely.
- PWM channel: on while pwm_cnt < duty.
  - duty=0 → constant off.
  - duty=2^PWM_BITS-1 → on for (2^PWM_BITS-1) of every 2^PWM_BITS ticks.
- BLINK channel:
  - A per-channel 16-bit counter increments on `frame`.
  - When it reaches max(period,1)-1 and `frame` is asserted, the counter clears and the phase toggles.
  - Phase 1 = on.
- Output: leds_export[k] = (enable ? raw[k] : 0) XOR invert.
- Unmapped addresses (including 4+N_CH and above) read 0; writes to them are ignored. Writes to read-only registers are ignored.
- Writing CHk clears that channel's blink counter and sets phase=1.
- Writing PRESC reloads the prescaler counter in the same cycle. The PWM counter is not affected.
- Writing CTRL with enable=0 clears the PWM counter, frame counter, all blink counters and all phases to 0. The prescaler is held at its reload value.
- Read and write to the same address in the same cycle: readdata returns the pre-write value.

## Timing
- Reset values: all registers 0, counters 0, blink phases 0, `leds_export`=0, `avs_readdata`=0.
- Read latency: exactly 1 cycle; `avs_readdata` is registered. No waitrequest. Writes take effect on the next edge.
- Output latency: a register write is visible on `leds_export` 2 cycles after the write cycle (register stage, then output flop).
- `tick` and `frame` are 1-cycle pulses. With PRESC=P, the PWM period is (P+1)·2^PWM_BITS cycles.
- Reset mid-operation: all state returns asynchronously to reset values. There is no partial-frame carry-over.

## Structure
- Package `led_pwm_pkg` holds:
  - the mode enum `led_mode_t` (OFF/ON/BLINK/PWM);
  - register word offsets (CTRL, PRESC, OUT, FRAME, CH_BASE=4);
  - CTRL bit indices.
- Sub-module `led_pwm_channel`, instantiated N_CH times:
  - inputs: mode, duty, period, pwm_cnt, frame, clear, enable;
  - internals: blink counter and phase;
  - output: `raw`.
- The top level holds the register file, prescaler, PWM/frame counters, read mux and output flop.

## Test plan
- Reset, then read all addresses → all 0, `leds_export`=0. Read address 4+N_CH → 0.
- CTRL=1, CH0 mode ON, CH1 mode OFF, PRESC=0 → `leds_export`=8'h01 two cycles after the CH0 write. CTRL=3 → 8'hFE.
- PWM_BITS=8, PRESC=0, CH2 PWM duty=64 → bit2 high 64 of every 256 cycles. duty=0 → never high. duty=255 → high 255 of 256.
- CH3 BLINK period=2, PRESC=0 → bit3 toggles every 512 cycles and starts high right after the write. Rewriting CH3 mid-period restarts the phase high.
- PRESC=3, then enable → FRAME pwm field increments once every 4 cycles. Writing CTRL enable=0 → FRAME reads 0 and outputs go 0.
- Assert `reset_reset_n` low mid-PWM, asynchronous to the clock → `leds_export` goes 0 without waiting for a clock edge, and registers read 0 after release.
